// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared grid geometry and flood-fill state encoding
package minesweeper_pkg;

  localparam int GRID_SIZE   = 8;
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
  localparam int INDEX_BITS  = $clog2(TOTAL_TILES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    APPLY  = 2'd2
  } flood_state_t;

endpackage

// File: rtl/flood_fill_if.sv
// rtl/flood_fill_if.sv - request/result bundle between tile-state store and flood_fill
interface flood_fill_if;
  import minesweeper_pkg::*;

  logic                   start;
  logic [INDEX_BITS-1:0]  start_index;
  logic [TOTAL_TILES-1:0] mine_mask;
  logic [TOTAL_TILES-1:0] zero_mask;
  logic [TOTAL_TILES-1:0] flagged;
  logic [TOTAL_TILES-1:0] revealed;
  logic [TOTAL_TILES-1:0] flood_update;
  logic                   flood_apply;
  logic                   busy;
  logic [INDEX_BITS:0]    tile_count;

  modport master (
    output start, start_index, mine_mask, zero_mask, flagged, revealed,
    input  flood_update, flood_apply, busy, tile_count
  );

  modport slave (
    input  start, start_index, mine_mask, zero_mask, flagged, revealed,
    output flood_update, flood_apply, busy, tile_count
  );

endinterface

// File: rtl/neighbor_mask.sv
// rtl/neighbor_mask.sv - combinational 8-neighbour mask of a tile, clipped at grid edges
module neighbor_mask
  import minesweeper_pkg::*;
(
  input  logic [INDEX_BITS-1:0]  i_index,
  output logic [TOTAL_TILES-1:0] o_mask
);

  int w_idx;
  int w_row;
  int w_col;

  assign w_idx = int'(i_index);
  assign w_row = w_idx / GRID_SIZE;
  assign w_col = w_idx % GRID_SIZE;

  // Row and column are compared separately, so a tile never wraps to the next row.
  for (genvar t = 0; t < TOTAL_TILES; t++) begin : g_tile
    localparam int TR = t / GRID_SIZE;
    localparam int TC = t % GRID_SIZE;
    assign o_mask[t] = (w_idx != t) &&
                       (w_row >= TR - 1) && (w_row <= TR + 1) &&
                       (w_col >= TC - 1) && (w_col <= TC + 1);
  end

endmodule

// File: rtl/flood_fill.sv
// rtl/flood_fill.sv - reveal-region engine: one tile per cycle cascade over a pending mask
module flood_fill
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  flood_fill_if.slave bus
);

  localparam int CW = INDEX_BITS + 1;

  flood_state_t           r_state;
  flood_state_t           w_next_state;
  logic [TOTAL_TILES-1:0] r_pending;
  logic [TOTAL_TILES-1:0] r_region;
  logic [TOTAL_TILES-1:0] r_update;
  logic                   r_apply;
  logic                   r_busy;
  logic [CW-1:0]          r_count;

  logic [TOTAL_TILES-1:0] w_pending_nxt;
  logic [TOTAL_TILES-1:0] w_region_nxt;
  logic [TOTAL_TILES-1:0] w_update_nxt;
  logic                   w_apply_nxt;
  logic                   w_busy_nxt;
  logic [CW-1:0]          w_count_nxt;

  logic [INDEX_BITS-1:0]  w_pick;
  logic [TOTAL_TILES-1:0] w_pick_onehot;
  logic [TOTAL_TILES-1:0] w_nbr;
  logic [TOTAL_TILES-1:0] w_grow;
  logic                   w_seed_ok;

  // Lowest set bit of pending wins.
  always_comb begin
    w_pick = '0;
    for (int i = TOTAL_TILES - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pick = INDEX_BITS'(i);
    end
  end

  assign w_pick_onehot = TOTAL_TILES'(1) << w_pick;

  neighbor_mask u_nbr (
    .i_index (w_pick),
    .o_mask  (w_nbr)
  );

  assign w_grow = w_nbr & ~r_region & ~r_pending & ~bus.mine_mask
                & ~bus.flagged & ~bus.revealed;

  // The store reveals the seed itself in the accept cycle, so revealed is not consulted here.
  assign w_seed_ok = !bus.mine_mask[bus.start_index] && !bus.flagged[bus.start_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = EXPAND;
      EXPAND:  if (r_pending == '0) w_next_state = APPLY;
      APPLY:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_pending_nxt = r_pending;
    w_region_nxt  = r_region;
    w_update_nxt  = r_update;
    w_apply_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_count_nxt   = r_count;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_region_nxt  = '0;
          w_pending_nxt = w_seed_ok ? (TOTAL_TILES'(1) << bus.start_index) : '0;
          w_update_nxt  = '0;
          w_count_nxt   = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      EXPAND: begin
        if (r_pending == '0) begin
          w_update_nxt = r_region;
          w_apply_nxt  = 1'b1;
        end else begin
          w_region_nxt  = r_region | w_pick_onehot;
          w_pending_nxt = (r_pending & ~w_pick_onehot)
                        | (bus.zero_mask[w_pick] ? w_grow : '0);
          w_count_nxt   = r_count + CW'(1);
        end
      end
      APPLY: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_region  <= '0;
      r_update  <= '0;
      r_apply   <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_region  <= w_region_nxt;
      r_update  <= w_update_nxt;
      r_apply   <= w_apply_nxt;
      r_busy    <= w_busy_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign bus.flood_update = r_update;
  assign bus.flood_apply  = r_apply;
  assign bus.busy         = r_busy;
  assign bus.tile_count   = r_count;

endmodule

// File: tb/tb_flood_fill.sv
// tb/tb_flood_fill.sv - randomized self-checking bench for flood_fill against a BFS model
module tb_flood_fill;
  import minesweeper_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flood_fill_if ffi();

  flood_fill dut (
    .clk (clk),
    .rst (rst),
    .bus (ffi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Breadth-first closure of the cascade rules over a plain array of tiles.
  function automatic void model(input int seed, input logic [63:0] mine, input logic [63:0] zero,
                                input logic [63:0] flag, input logic [63:0] rev,
                                output logic [63:0] region, output int cnt);
    int q[$];
    int p, r, c, n;
    region = '0;
    if (!mine[seed] && !flag[seed]) begin
      region[seed] = 1'b1;
      q.push_back(seed);
    end
    while (q.size() > 0) begin
      p = q.pop_front();
      if (zero[p]) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            r = p / GRID_SIZE + dr;
            c = p % GRID_SIZE + dc;
            if ((dr != 0 || dc != 0) && r >= 0 && r < GRID_SIZE && c >= 0 && c < GRID_SIZE) begin
              n = r * GRID_SIZE + c;
              if (!region[n] && !mine[n] && !flag[n] && !rev[n]) begin
                region[n] = 1'b1;
                q.push_back(n);
              end
            end
          end
        end
      end
    end
    cnt = $countones(region);
  endfunction

  task automatic run_flood(input string tag, input int seed, input logic [63:0] mine,
                           input logic [63:0] zero, input logic [63:0] flag,
                           input logic [63:0] rev, input bit mid_start);
    logic [63:0] exp_reg;
    int exp_n;
    int n;
    bit seen;
    bit busy_ok;
    model(seed, mine, zero, flag, rev, exp_reg, exp_n);
    @(negedge clk);
    ffi.mine_mask   = mine;
    ffi.zero_mask   = zero;
    ffi.flagged     = flag;
    ffi.revealed    = rev;
    ffi.start_index = INDEX_BITS'(seed);
    ffi.start       = 1'b1;
    @(negedge clk);
    ffi.start = 1'b0;
    check({tag, "/busy_after_start"}, 64'(ffi.busy), 64'd1);
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (mid_start && exp_n >= 2 && n == 2) begin
        ffi.start       = 1'b1;
        ffi.start_index = INDEX_BITS'($urandom_range(0, TOTAL_TILES - 1));
      end else begin
        ffi.start = 1'b0;
      end
      if (ffi.flood_apply) seen = 1'b1;
      else if (!ffi.busy) busy_ok = 1'b0;
    end
    ffi.start = 1'b0;
    check({tag, "/apply_latency"}, seen ? 64'(n + 1) : 64'd0, 64'(exp_n + 2));
    check({tag, "/busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "/flood_update"}, ffi.flood_update, exp_reg);
    check({tag, "/tile_count"}, 64'(ffi.tile_count), 64'(exp_n));
    check({tag, "/busy_in_apply"}, 64'(ffi.busy), 64'd1);
    @(negedge clk);
    check({tag, "/apply_one_cycle"}, 64'(ffi.flood_apply), 64'd0);
    check({tag, "/busy_idle"}, 64'(ffi.busy), 64'd0);
    check({tag, "/update_hold"}, ffi.flood_update, exp_reg);
    check({tag, "/count_hold"}, 64'(ffi.tile_count), 64'(exp_n));
  endtask

  function automatic logic [63:0] rand_mask(input int pct);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) m[i] = ($urandom_range(0, 99) < pct);
    return m;
  endfunction

  initial begin
    logic [63:0] ones;
    bit apply_seen;
    ones = '1;
    ffi.start       = 1'b0;
    ffi.start_index = '0;
    ffi.mine_mask   = '0;
    ffi.zero_mask   = '0;
    ffi.flagged     = '0;
    ffi.revealed    = '0;

    repeat (3) @(negedge clk);
    check("reset/update", ffi.flood_update, 64'd0);
    check("reset/apply", 64'(ffi.flood_apply), 64'd0);
    check("reset/busy", 64'(ffi.busy), 64'd0);
    check("reset/count", 64'(ffi.tile_count), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset/busy", 64'(ffi.busy), 64'd0);
    check("post_reset/update", ffi.flood_update, 64'd0);

    run_flood("seed0_plain", 0, '0, '0, '0, '0, 1'b0);
    run_flood("seed9_zero", 9, '0, 64'd1 << 9, '0, '0, 1'b0);
    run_flood("corner7", 7, '0, 64'd1 << 7, '0, '0, 1'b0);
    run_flood("full_grid", 0, '0, ones, '0, '0, 1'b0);
    run_flood("full_flag27", 0, '0, ones, 64'd1 << 27, '0, 1'b0);
    run_flood("seed_flagged", 5, '0, ones, 64'd1 << 5, '0, 1'b0);
    run_flood("seed_mine", 5, 64'd1 << 5, ones, '0, '0, 1'b0);
    run_flood("seed_revealed", 12, '0, '0, '0, 64'd1 << 12, 1'b0);
    run_flood("midstart_full", 63, '0, ones, '0, '0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run_flood($sformatf("rand%0d", k), $urandom_range(0, TOTAL_TILES - 1),
                rand_mask(15), rand_mask(65), rand_mask(5), rand_mask(10), k[0]);
    end

    @(negedge clk);
    ffi.mine_mask   = '0;
    ffi.zero_mask   = ones;
    ffi.flagged     = '0;
    ffi.revealed    = '0;
    ffi.start_index = '0;
    ffi.start       = 1'b1;
    @(negedge clk);
    ffi.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort/busy", 64'(ffi.busy), 64'd0);
    check("abort/apply", 64'(ffi.flood_apply), 64'd0);
    check("abort/count", 64'(ffi.tile_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (ffi.flood_apply) apply_seen = 1'b1;
    end
    check("abort/no_apply", 64'(apply_seen), 64'd0);

    run_flood("after_abort", 27, '0, 64'd1 << 27, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flood_fill.md
# flood_fill

Reveal-region engine for the minesweeper grid. Given a seed tile, it finds every tile that an empty-area cascade opens. It walks the region one tile per cycle using a pending/visited bitmask and a priority encoder. It drives the `flood_update` / `flood_apply` inputs of the tile-state store directly downstream, which ORs the mask into its persistent `revealed` array.

## Interface
- `GRID_SIZE`, 8, tiles per row/column (square grid)
- `TOTAL_TILES`, GRID_SIZE*GRID_SIZE, tile count
- `INDEX_BITS`, $clog2(TOTAL_TILES), tile index width; tile index = row*GRID_SIZE + col

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to flood from `start_index`
- `start_index`  in  INDEX_BITS  seed tile
- `mine_mask`  in  TOTAL_TILES  1 = tile holds a mine
- `zero_mask`  in  TOTAL_TILES  1 = tile has zero adjacent mines
- `flagged`  in  TOTAL_TILES  current flag state
- `revealed`  in  TOTAL_TILES  current reveal state
- `flood_update`  out  TOTAL_TILES  region mask; valid while `flood_apply`=1
- `flood_apply`  out  1  one-cycle pulse, region complete
- `busy`  out  1  high from the cycle after `start` is accepted through the APPLY cycle
- `tile_count`  out  INDEX_BITS+1  number of bits set in `flood_update`

## Operation
- States: IDLE, EXPAND, APPLY.
- **IDLE**
  - `start`=1 is accepted.
  - `region` is cleared.
  - The seed is eligible if it is not a mine and not flagged. Eligibility ignores `revealed`, because tile-state reveals the seed in the same cycle.
  - `pending` is loaded with the seed bit if eligible, else with 0.
  - Next state is EXPAND.
- **EXPAND, pending == 0**
  - Next state is APPLY.
- **EXPAND, pending != 0**
  - p = lowest set index of `pending`.
  - Set `region[p]`; clear `pending[p]`; `tile_count` += 1.
  - If `zero_mask[p]`: `pending |= nbr(p) & ~region & ~pending & ~mine_mask & ~flagged & ~revealed`.
  - Stay in EXPAND.
- **APPLY**
  - `flood_apply`=1 for exactly one cycle, with `flood_update` = `region`.
  - Next state is IDLE.
- `nbr(p)` covers the up to 8 orthogonal and diagonal neighbours.
  - No wrap across row edges or grid edges.
  - Corner tiles have 3 neighbours, edge tiles 5, interior tiles 8.
- Numbered (non-zero) tiles join the region but do not propagate.
- Mines never enter the region.
- `start` is ignored while `busy`=1. There is no queueing.
- Mask inputs must stay stable while `busy`. Upstream guarantees this; the block does not re-sample them for consistency.
- A non-eligible seed completes with an empty mask: `flood_apply` still pulses, with `flood_update`=0 and `tile_count`=0.

## Timing
- Reset (async assert, any state): state=IDLE, `pending`=0, `region`=0, `flood_update`=0, `flood_apply`=0, `busy`=0, `tile_count`=0.
- Reset mid-EXPAND aborts the flood; no `flood_apply` is issued.
- Let `start` be sampled at edge T with N region tiles:
  - EXPAND occupies cycles T+1 .. T+N+1.
  - APPLY (the `flood_apply` pulse) is cycle T+N+2.
  - IDLE resumes at T+N+3.
  - A new `start` is accepted at T+N+3 at the earliest.
- Worst case N=TOTAL_TILES: 66 cycles for the default grid.
- `flood_update` and `tile_count` are registered. They hold their values after APPLY until the next accepted `start` clears them.
- `busy` is registered and is high exactly during EXPAND and APPLY.

## Structure
- Shared package `minesweeper_pkg`:
  - `GRID_SIZE`, `TOTAL_TILES`, `INDEX_BITS`.
  - The state enum `flood_state_t` {IDLE, EXPAND, APPLY}.
- Sub-module `neighbor_mask`:
  - Combinational, index in, TOTAL_TILES-wide neighbour mask out.
  - Derives row/col from the index and handles edges.
  - Reusable by the adjacency-count generator.
- The lowest-set-bit priority encoder stays inside `flood_fill`.

## Test plan
- Reset, then `start` with no masks set. Required during and after reset: all outputs 0, state IDLE, `busy`=0. After `start` at T, seed 0: `flood_apply` at T+3, `flood_update`=0x1, `tile_count`=1.
- Seed 9, `zero_mask`=bit 9 only, no mines/flags. Required: `flood_update` = bits {0,1,2,8,9,10,16,17,18}, `tile_count`=9, `flood_apply` at T+11.
- Seed 7 (corner), `zero_mask`=bit 7 only. Required: `flood_update` = bits {6,7,14,15}; bit 8 clear (no wrap).
- Seed 0 with `zero_mask`=all ones, `mine_mask`=0. Required: `flood_update`=all ones, `tile_count`=64, `flood_apply` at T+66. Repeat with `flagged` bit 27 set: bit 27 is excluded and `tile_count`=63.
- Seed flagged, or seed is a mine. Required: `flood_apply` at T+2, `flood_update`=0, `tile_count`=0.
- `start` pulsed mid-EXPAND: ignored; the original result is unchanged. `rst` asserted mid-EXPAND: no `flood_apply` follows, and `busy`=0 immediately.
